// File: rtl/rsa_pkg.sv
// Shared constants, FSM state types and the modular-multiply step used by the RSA stream decoder.
package rsa_pkg;

  localparam int STREAM_W  = 1023;
  localparam int CHAR_W    = 7;
  localparam int CIPH_W    = 14;
  localparam int MAX_CHARS = 146;
  localparam int MAX_CIPH  = 73;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_EXP_ENC = 3'd2,
    ST_EXP_DEC = 3'd3,
    ST_STORE   = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ME_IDLE = 2'd0,
    ME_SQ   = 2'd1,
    ME_MUL  = 2'd2,
    ME_DONE = 2'd3
  } me_state_e;

  // One interleaved step: r' = (2r + b_bit*a) mod n, with r, a < n so every partial stays below 2n.
  function automatic logic [CIPH_W-1:0] mm_step(input logic [CIPH_W-1:0] r,
                                                input logic [CIPH_W-1:0] a,
                                                input logic [CIPH_W-1:0] n,
                                                input logic              b_bit);
    logic [CIPH_W:0] dbl;
    logic [CIPH_W:0] dbl_red;
    logic [CIPH_W:0] sum;
    logic [CIPH_W:0] sum_red;
    dbl     = {r, 1'b0};
    dbl_red = (dbl >= {1'b0, n}) ? (dbl - {1'b0, n}) : dbl;
    sum     = dbl_red + (b_bit ? {1'b0, a} : {(CIPH_W+1){1'b0}});
    sum_red = (sum >= {1'b0, n}) ? (sum - {1'b0, n}) : sum;
    return CIPH_W'(sum_red);
  endfunction

endpackage

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation over a 14-bit exponent,
// built on a bit-serial interleaved modular multiplier (14 cycles per multiply).
module rsa_modexp
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CIPH_W-1:0] base,
  input  logic [CIPH_W-1:0] exponent,
  input  logic [CIPH_W-1:0] modulus,
  output logic [CIPH_W-1:0] result,
  output logic              done
);

  me_state_e         state_q, state_d;
  logic [CIPH_W-1:0] base_q, base_d;
  logic [CIPH_W-1:0] exp_q, exp_d;
  logic [CIPH_W-1:0] acc_q, acc_d;
  logic [CIPH_W-1:0] r_q, r_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        ebit_q, ebit_d;
  logic [CIPH_W-1:0] result_q, result_d;
  logic              done_q, done_d;

  logic              b_bit;
  logic [CIPH_W-1:0] r_step;
  logic              sq_skip;

  // The multiplicand is always the reduced accumulator; the unreduced base only ever
  // appears as the serial multiplier operand, so a ciphertext >= N needs no pre-reduction.
  assign b_bit   = (state_q == ME_MUL) ? base_q[cnt_q] : acc_q[cnt_q];
  assign r_step  = mm_step(r_q, acc_q, modulus, b_bit);
  assign sq_skip = (acc_q == {{(CIPH_W-1){1'b0}}, 1'b1}) && (cnt_q == 4'd13);

  // Next-state and datapath for the exponentiation sequencer.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    ebit_d   = ebit_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ME_IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exponent;
          acc_d   = {{(CIPH_W-1){1'b0}}, 1'b1};
          r_d     = {CIPH_W{1'b0}};
          cnt_d   = 4'd13;
          ebit_d  = 4'd13;
          state_d = ME_SQ;
        end else begin
          state_d = ME_IDLE;
        end
      end
      ME_SQ: begin
        // Squaring 1 is free, which skips the leading zero bits of the exponent quickly.
        if (sq_skip || (cnt_q == 4'd0)) begin
          acc_d = sq_skip ? acc_q : r_step;
          r_d   = {CIPH_W{1'b0}};
          cnt_d = 4'd13;
          if (exp_q[ebit_q]) begin
            state_d = ME_MUL;
          end else if (ebit_q == 4'd0) begin
            state_d = ME_DONE;
          end else begin
            ebit_d = ebit_q - 4'd1;
          end
        end else begin
          r_d   = r_step;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ME_MUL: begin
        if (cnt_q == 4'd0) begin
          acc_d = r_step;
          r_d   = {CIPH_W{1'b0}};
          cnt_d = 4'd13;
          if (ebit_q == 4'd0) begin
            state_d = ME_DONE;
          end else begin
            ebit_d  = ebit_q - 4'd1;
            state_d = ME_SQ;
          end
        end else begin
          r_d   = r_step;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ME_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = ME_IDLE;
      end
      default: begin
        state_d = ME_IDLE;
      end
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ME_IDLE;
      base_q   <= {CIPH_W{1'b0}};
      exp_q    <= {CIPH_W{1'b0}};
      acc_q    <= {CIPH_W{1'b0}};
      r_q      <= {CIPH_W{1'b0}};
      cnt_q    <= 4'd0;
      ebit_q   <= 4'd0;
      result_q <= {CIPH_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      ebit_q   <= ebit_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: rtl/en_decoder_rsa.sv
// RSA stream decoder: walks the packed input slot by slot, runs each slot through
// encrypt+decrypt (mode 0) or decrypt only (mode 1), and packs 7-bit results MSB-first.
module en_decoder_rsa
  import rsa_pkg::*;
#(
  parameter int P = 61,
  parameter int Q = 53,
  parameter int N = 3233,
  parameter int E = 17,
  parameter int D = 2753
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STREAM_W-1:0] in_stream,
  input  logic                mode,
  output logic [STREAM_W-1:0] out_stream,
  output logic                busy,
  output logic                done
);

  if ((N < 128) || (N > 16383) || (P < 2) || (Q < 2)) begin : g_param_check
    $error("en_decoder_rsa: N must lie in 128..16383 and P, Q must be primes");
  end

  localparam logic [CIPH_W-1:0] N_L = CIPH_W'(N);
  localparam logic [CIPH_W-1:0] E_L = CIPH_W'(E);
  localparam logic [CIPH_W-1:0] D_L = CIPH_W'(D);

  state_e              state_q, state_d;
  logic [STREAM_W-1:0] in_q, in_d;
  logic [STREAM_W-1:0] out_q, out_d;
  logic                mode_q, mode_d;
  logic [7:0]          slot_q, slot_d;
  logic [CIPH_W-1:0]   val_q, val_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic                term_q, term_d;
  logic                me_start_q, me_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CIPH_W-1:0]   slot_val;
  logic [CIPH_W-1:0]   me_exp;
  logic [CIPH_W-1:0]   me_result;
  logic                me_done;
  logic [10:0]         shamt;
  logic [STREAM_W-1:0] keep_mask;
  logic [STREAM_W-1:0] char_field;
  logic                last_slot;

  // The unconsumed input is kept left-justified, so the current slot is always at the top.
  assign slot_val   = mode_q ? in_q[STREAM_W-1 -: CIPH_W]
                             : {{(CIPH_W-CHAR_W){1'b0}}, in_q[STREAM_W-1 -: CHAR_W]};
  assign me_exp     = (state_q == ST_EXP_ENC) ? E_L : D_L;
  assign shamt      = 11'(slot_q) * 11'd7;
  assign keep_mask  = ~({STREAM_W{1'b1}} >> shamt);
  assign char_field = {char_q, {(STREAM_W-CHAR_W){1'b0}}};
  assign last_slot  = mode_q ? (slot_q == 8'(MAX_CIPH - 1)) : (slot_q == 8'(MAX_CHARS - 1));

  rsa_modexp u_modexp (
    .clk      (clk),
    .rst      (rst),
    .start    (me_start_q),
    .base     (val_q),
    .exponent (me_exp),
    .modulus  (N_L),
    .result   (me_result),
    .done     (me_done)
  );

  // Slot-sequencing FSM with the input/output register updates.
  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    out_d      = out_q;
    mode_d     = mode_q;
    slot_d     = slot_q;
    val_d      = val_q;
    char_d     = char_q;
    term_d     = term_q;
    me_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          in_d    = in_stream;
          mode_d  = mode;
          slot_d  = 8'd0;
          term_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (slot_val == {CIPH_W{1'b0}}) begin
          char_d  = {CHAR_W{1'b0}};
          term_d  = 1'b1;
          state_d = ST_STORE;
        end else begin
          val_d      = slot_val;
          term_d     = 1'b0;
          me_start_d = 1'b1;
          state_d    = mode_q ? ST_EXP_DEC : ST_EXP_ENC;
        end
      end
      ST_EXP_ENC: begin
        if (me_done) begin
          val_d      = me_result;
          me_start_d = 1'b1;
          state_d    = ST_EXP_DEC;
        end else begin
          state_d = ST_EXP_ENC;
        end
      end
      ST_EXP_DEC: begin
        if (me_done) begin
          char_d  = me_result[CHAR_W-1:0];
          state_d = ST_STORE;
        end else begin
          state_d = ST_EXP_DEC;
        end
      end
      ST_STORE: begin
        // Writing a slot also clears everything below it, so stale bits from an earlier
        // run never survive past the terminator or the last slot.
        out_d = (out_q & keep_mask) | (char_field >> shamt);
        in_d  = mode_q ? (in_q << CIPH_W) : (in_q << CHAR_W);
        if (term_q || last_slot) begin
          state_d = ST_FINISH;
        end else begin
          slot_d  = slot_q + 8'd1;
          state_d = ST_LOAD;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, stream and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_q       <= {STREAM_W{1'b0}};
      out_q      <= {STREAM_W{1'b0}};
      mode_q     <= 1'b0;
      slot_q     <= 8'd0;
      val_q      <= {CIPH_W{1'b0}};
      char_q     <= {CHAR_W{1'b0}};
      term_q     <= 1'b0;
      me_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      out_q      <= out_d;
      mode_q     <= mode_d;
      slot_q     <= slot_d;
      val_q      <= val_d;
      char_q     <= char_d;
      term_q     <= term_d;
      me_start_q <= me_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_stream = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_en_decoder_rsa.sv
// Directed bench for en_decoder_rsa: default-parameter instance plus a second key set.
module tb_en_decoder_rsa;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, mode_a, busy_a, done_a;
  logic [1022:0] in_a, out_a;
  logic          start_b, mode_b, busy_b, done_b;
  logic [1022:0] in_b, out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  en_decoder_rsa dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_stream(in_a), .mode(mode_a),
    .out_stream(out_a), .busy(busy_a), .done(done_a)
  );

  en_decoder_rsa #(.P(97), .Q(109), .N(10573), .E(89), .D(233)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_stream(in_b), .mode(mode_b),
    .out_stream(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint modpow(input longint b, input longint e, input longint n);
    longint r = 1;
    longint bb = b % n;
    longint ee = e;
    while (ee > 0) begin
      if ((ee & 1) == 1) r = (r * bb) % n;
      bb = (bb * bb) % n;
      ee = ee >> 1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic m, input logic [1022:0] v);
    mode_a = m; in_a = v; start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic m, input logic [1022:0] v);
    mode_b = m; in_b = v; start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  task automatic wait_a(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (done_a !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk(tag, {63'd0, done_a}, 64'd1);
  endtask

  task automatic wait_b(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (done_b !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk(tag, {63'd0, done_b}, 64'd1);
  endtask

  initial begin
    logic [1022:0] v_hi, v, tmp;
    longint        c65, c72, cb;
    int            cyc, lat_hi, cyc2;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode_a = 1'b0; mode_b = 1'b0; in_a = '0; in_b = '0;
    repeat (3) tick();
    chk("rst_out", {63'd0, |out_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    rst = 1'b0;
    tick();

    // Mode 0 round trip of "Hi"
    v_hi = '0;
    v_hi[1022:1009] = {7'h48, 7'h69};
    pulse_a(1'b0, v_hi);
    chk("hi_busy", {63'd0, busy_a}, 64'd1);
    wait_a("hi_done", 4000, lat_hi);
    chk("hi_chars", {50'd0, out_a[1022:1009]}, {50'd0, 7'h48, 7'h69});
    chk("hi_rest", {63'd0, |out_a[1008:0]}, 64'd0);
    chk("hi_busy_low", {63'd0, busy_a}, 64'd0);
    tick();
    chk("hi_done_pulse", {63'd0, done_a}, 64'd0);
    chk("hi_stable", {50'd0, out_a[1022:1009]}, {50'd0, 7'h48, 7'h69});

    // Mode 1 decrypt of 'A'
    c65 = modpow(65, 17, 3233);
    c72 = modpow(72, 17, 3233);
    v = '0;
    v[1022:1009] = 14'(c65);
    pulse_a(1'b1, v);
    wait_a("a_done", 2000, cyc);
    chk("a_char", {57'd0, out_a[1022:1016]}, 64'd65);
    chk("a_rest", {63'd0, |out_a[1015:0]}, 64'd0);

    // Ciphertext above N must be reduced first
    v = '0;
    v[1022:1009] = 14'(c65 + 3233);
    pulse_a(1'b1, v);
    wait_a("big_done", 2000, cyc);
    chk("big_char", {57'd0, out_a[1022:1016]}, 64'd65);

    // Two ciphertext slots "AH"
    v = '0;
    v[1022:1009] = 14'(c65);
    v[1008:995]  = 14'(c72);
    pulse_a(1'b1, v);
    wait_a("ah_done", 4000, cyc);
    chk("ah_chars", {50'd0, out_a[1022:1009]}, {50'd0, 7'd65, 7'd72});
    chk("ah_rest", {63'd0, |out_a[1008:0]}, 64'd0);

    // Alternate key set
    cb = modpow(72, 89, 10573);
    v = '0;
    v[1022:1009] = 14'(cb);
    pulse_b(1'b1, v);
    wait_b("b_done", 2000, cyc);
    chk("b_char", {57'd0, out_b[1022:1016]}, 64'd72);
    chk("b_rest", {63'd0, |out_b[1015:0]}, 64'd0);

    // Full mode 0 stream of 146 '~' characters
    v = '0;
    for (int i = 0; i < 146; i++) v[1022 - 7*i -: 7] = 7'h7E;
    pulse_a(1'b0, v);
    wait_a("full_done", 130000, cyc);
    chk("full_latency", {63'd0, (cyc + 1) <= (146*2*430 + 4)}, 64'd1);
    for (int i = 0; i < 146; i++) begin
      tmp = out_a << (7*i);
      chk($sformatf("full_slot%0d", i), {57'd0, tmp[1022:1016]}, 64'h7E);
    end
    chk("full_bit0", {63'd0, out_a[0]}, 64'd0);

    // Reset in mid-run, together with a start request
    pulse_a(1'b0, v_hi);
    repeat (50) tick();
    rst = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("midrst_out", {63'd0, |out_a}, 64'd0);
    chk("midrst_busy", {63'd0, busy_a}, 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_idle", {63'd0, busy_a}, 64'd0);
    pulse_a(1'b0, v_hi);
    wait_a("rerun_done", 4000, cyc);
    chk("rerun_chars", {50'd0, out_a[1022:1009]}, {50'd0, 7'h48, 7'h69});
    chk("rerun_latency", 64'(cyc), 64'(lat_hi));
    tick();

    // Start while busy is ignored
    pulse_a(1'b0, v_hi);
    repeat (3) tick();
    v = '1;
    pulse_a(1'b1, v);
    wait_a("dbl_done", 4000, cyc2);
    chk("dbl_latency", 64'(cyc2 + 4), 64'(lat_hi));
    chk("dbl_chars", {50'd0, out_a[1022:1009]}, {50'd0, 7'h48, 7'h69});
    chk("dbl_rest", {63'd0, |out_a[1008:0]}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
